// File: rtl/ca90_hier_decoder.sv
// ca90_hier_decoder
//   Receives a hierarchical CA90 hypervector as a stream of ChunkWidth-bit
//   words (lowest bits first), then verifies layer by layer (one layer per
//   cycle) that each doubled layer equals the circular rule-90 image of the
//   layer below it. It reports the layer-0 seed and a match flag.
//
// Parameters
//   HVDimension : streamed HV width, SeedWidth*2^L with L >= 1
//   SeedWidth   : seed (layer-0) width
//   ChunkWidth  : input word width, divides SeedWidth and HVDimension
//
// Ports
//   clk_i, rst_ni                : clock, synchronous active-low reset
//   hv_chunk_i/hv_valid_i/hv_ready_o : HV word stream
//   seed_o, match_o              : recovered seed and consistency flag
//   result_valid_o/result_ready_i: result handshake
//   err_layer_o [3:0]            : first mismatching layer, 4'hF if none
//                                  (only with CA90_HIER_DEC_ERR_LAYER_EN)
module ca90_hier_decoder #(
  parameter int unsigned HVDimension = 512,
  parameter int unsigned SeedWidth   = 32,
  parameter int unsigned ChunkWidth  = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [ChunkWidth-1:0] hv_chunk_i,
  input  logic                  hv_valid_i,
  output logic                  hv_ready_o,
  output logic [SeedWidth-1:0]  seed_o,
  output logic                  match_o,
  output logic                  result_valid_o,
  input  logic                  result_ready_i
`ifdef CA90_HIER_DEC_ERR_LAYER_EN
  ,
  output logic [3:0]            err_layer_o
`endif
);

  localparam int unsigned Layers    = $clog2(HVDimension / SeedWidth);
  localparam int unsigned NumChunks = HVDimension / ChunkWidth;
  localparam int unsigned CntW      = (NumChunks > 1) ? $clog2(NumChunks) : 1;
  localparam int unsigned LayW      = (Layers > 1) ? $clog2(Layers) : 1;

  typedef enum logic [1:0] {
    RX,
    CHECK,
    DONE
  } state_t;

  state_t                 state;
  logic [CntW-1:0]        count;
  logic [LayW-1:0]        layer;
  logic [HVDimension-1:0] buffer;
  logic [Layers-1:0]      layer_bad;

  // Every layer is compared combinationally; CHECK just walks the index,
  // which keeps the variable-width comparison out of the sequential logic.
  for (genvar k = 0; k < Layers; k++) begin : g_layer
    localparam int unsigned W = SeedWidth << k;
    logic [W-1:0] low;
    logic [W-1:0] ca90;
    assign low  = buffer[W-1:0];
    // out[i] = v[i+1] ^ v[i-1], circular: rotate-right XOR rotate-left
    assign ca90 = {low[0], low[W-1:1]} ^ {low[W-2:0], low[W-1]};
    assign layer_bad[k] = (buffer[2*W-1:W] != ca90);
  end

  assign seed_o     = buffer[SeedWidth-1:0];
  // Gated by reset so the stream is stalled while reset is asserted.
  assign hv_ready_o = rst_ni && (state == RX);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state          <= RX;
      count          <= '0;
      layer          <= '0;
      buffer         <= '0;
      match_o        <= 1'b0;
      result_valid_o <= 1'b0;
`ifdef CA90_HIER_DEC_ERR_LAYER_EN
      err_layer_o    <= 4'hF;
`endif
    end else begin
      case (state)
        RX: begin
          if (hv_valid_i) begin
            buffer[count*ChunkWidth +: ChunkWidth] <= hv_chunk_i;
            if (count == CntW'(NumChunks - 1)) begin
              count   <= '0;
              layer   <= '0;
              match_o <= 1'b1;
`ifdef CA90_HIER_DEC_ERR_LAYER_EN
              err_layer_o <= 4'hF;
`endif
              state   <= CHECK;
            end else begin
              count <= count + 1'b1;
            end
          end
        end
        CHECK: begin
          if (layer_bad[layer]) begin
            match_o <= 1'b0;
`ifdef CA90_HIER_DEC_ERR_LAYER_EN
            // match_o still set means no earlier layer has failed
            if (match_o) err_layer_o <= 4'(layer);
`endif
          end
          if (layer == LayW'(Layers - 1)) begin
            state          <= DONE;
            result_valid_o <= 1'b1;
          end else begin
            layer <= layer + 1'b1;
          end
        end
        DONE: begin
          if (result_ready_i) begin
            state          <= RX;
            result_valid_o <= 1'b0;
          end
        end
        default: state <= RX;
      endcase
    end
  end

endmodule

// File: tb/tb_ca90_hier_decoder.sv
// tb_ca90_hier_decoder
//   Scoreboard bench: the driver streams HVs and pushes the reference-model
//   result; a monitor pops and compares when result_valid_o appears, and
//   also checks latency, output stability and ready behaviour in DONE.
module tb_ca90_hier_decoder;

  localparam int HV  = 512;
  localparam int SW  = 32;
  localparam int CW  = 32;
  localparam int NCH = HV / CW;
  localparam int L   = 4;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic [CW-1:0] hv_chunk_i = '0;
  logic          hv_valid_i = 1'b0;
  logic          hv_ready_o;
  logic [SW-1:0] seed_o;
  logic          match_o;
  logic          result_valid_o;
  logic          result_ready_i = 1'b0;
`ifdef CA90_HIER_DEC_ERR_LAYER_EN
  logic [3:0]    err_layer_o;
`endif

  ca90_hier_decoder #(
    .HVDimension(HV),
    .SeedWidth  (SW),
    .ChunkWidth (CW)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .hv_chunk_i    (hv_chunk_i),
    .hv_valid_i    (hv_valid_i),
    .hv_ready_o    (hv_ready_o),
    .seed_o        (seed_o),
    .match_o       (match_o),
    .result_valid_o(result_valid_o),
    .result_ready_i(result_ready_i)
`ifdef CA90_HIER_DEC_ERR_LAYER_EN
    ,
    .err_layer_o   (err_layer_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [SW-1:0] seed;
    bit            match;
    logic [3:0]    err;
    int            t;
    int            hold;
  } exp_t;

  exp_t exp_q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Reference model: build the hierarchy straight from the rule-90 definition.
  function automatic logic [HV-1:0] expand(input logic [SW-1:0] seed);
    logic [HV-1:0] h = '0;
    h[SW-1:0] = seed;
    for (int k = 0; k < L; k++) begin
      int w = SW << k;
      for (int i = 0; i < w; i++)
        h[w+i] = h[(i+1)%w] ^ h[(i+w-1)%w];
    end
    return h;
  endfunction

  function automatic void judge(input logic [HV-1:0] h, output bit m, output logic [3:0] e);
    m = 1'b1;
    e = 4'hF;
    for (int k = 0; k < L; k++) begin
      int w = SW << k;
      bit bad = 1'b0;
      for (int i = 0; i < w; i++)
        if (h[w+i] != (h[(i+1)%w] ^ h[(i+w-1)%w])) bad = 1'b1;
      if (bad && m) begin
        m = 1'b0;
        e = 4'(k);
      end
    end
  endfunction

  // Streams the first n chunks of hv; when push is set and all chunks went
  // through, the expected result is queued at the final handshake.
  task automatic send(input logic [HV-1:0] hv, input int n, input bit gaps,
                      input bit push, input int hold);
    int  c = 0;
    int  guard = 0;
    bit  hs;
    bit  m;
    logic [3:0] e;
    exp_t x;
    judge(hv, m, e);
    while (c < n) begin
      hv_valid_i = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      hv_chunk_i = hv_valid_i ? hv[c*CW +: CW] : CW'($urandom);
      @(negedge clk_i);
      hs = hv_valid_i && hv_ready_o;
      if (hs && c == NCH - 1 && push) begin
        x.seed = hv[SW-1:0];
        x.match = m;
        x.err = e;
        x.t = cyc;
        x.hold = hold;
        exp_q.push_back(x);
      end
      @(posedge clk_i);
      #1;
      if (hs) c++;
      guard++;
      if (guard > 2000) begin
        $display("FAIL send_timeout: got %0d chunks expected %0d", c, n);
        $fatal(1, "stream stalled");
      end
    end
    hv_valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || result_valid_o) && n < 1000) begin
      @(negedge clk_i);
      n++;
    end
    chk("idle_timeout", 64'(exp_q.size() != 0 || result_valid_o), 64'd0);
    @(posedge clk_i);
    #1;
  endtask

  // Monitor / scoreboard
  bit            in_done = 0;
  int            hold_cnt = 0;
  logic [SW-1:0] held_seed;
  logic          held_match;
`ifdef CA90_HIER_DEC_ERR_LAYER_EN
  logic [3:0]    held_err;
`endif

  initial begin
    exp_t x;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        in_done = 0;
        result_ready_i = 1'b0;
      end else if (result_valid_o) begin
        if (!in_done) begin
          in_done = 1;
          if (exp_q.size() == 0) begin
            chk("unexpected_result", 64'd1, 64'd0);
            hold_cnt = 0;
          end else begin
            x = exp_q.pop_front();
            chk("seed", 64'(seed_o), 64'(x.seed));
            chk("match", 64'(match_o), 64'(x.match));
            chk("latency", 64'(cyc - x.t), 64'(L + 1));
`ifdef CA90_HIER_DEC_ERR_LAYER_EN
            chk("err_layer", 64'(err_layer_o), 64'(x.err));
`endif
            hold_cnt = x.hold;
          end
          held_seed = seed_o;
          held_match = match_o;
`ifdef CA90_HIER_DEC_ERR_LAYER_EN
          held_err = err_layer_o;
`endif
        end else begin
          chk("seed_stable", 64'(seed_o), 64'(held_seed));
          chk("match_stable", 64'(match_o), 64'(held_match));
`ifdef CA90_HIER_DEC_ERR_LAYER_EN
          chk("err_stable", 64'(err_layer_o), 64'(held_err));
`endif
        end
        chk("ready_in_done", 64'(hv_ready_o), 64'd0);
        if (hold_cnt == 0) result_ready_i = 1'b1;
        else begin
          hold_cnt--;
          result_ready_i = 1'b0;
        end
      end else begin
        if (in_done) begin
          in_done = 0;
          chk("ready_after_result", 64'(hv_ready_o), 64'd1);
        end
        result_ready_i = ($urandom_range(0, 1) == 1);
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [HV-1:0] h;
    logic [HV-1:0] base;
    int            b;
    int            mode;

    // reset state
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_ready", 64'(hv_ready_o), 64'd0);
    chk("rst_seed", 64'(seed_o), 64'd0);
    chk("rst_match", 64'(match_o), 64'd0);
    chk("rst_valid", 64'(result_valid_o), 64'd0);
`ifdef CA90_HIER_DEC_ERR_LAYER_EN
    chk("rst_err", 64'(err_layer_o), 64'hF);
`endif
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("ready_after_rst", 64'(hv_ready_o), 64'd1);
    @(posedge clk_i);
    #1;

    // directed cases
    base = expand(32'h0000_0001);
    send(base, NCH, 1'b0, 1'b1, 0);
    wait_idle();
    send('0, NCH, 1'b0, 1'b1, 0);
    h = base;
    h[40] = ~h[40];
    send(h, NCH, 1'b0, 1'b1, 1);
    h = base;
    h[300] = ~h[300];
    send(h, NCH, 1'b0, 1'b1, 2);
    wait_idle();

    // gaps plus a long-held result, then a following stream
    send(expand(SW'($urandom)), NCH, 1'b1, 1'b1, 10);
    send(expand(SW'($urandom)), NCH, 1'b1, 1'b1, 0);
    wait_idle();

    // reset after chunk 7, then a fresh stream
    send(expand(32'h1234_5678), 8, 1'b0, 1'b0, 0);
    rst_ni = 1'b0;
    @(negedge clk_i);
    chk("ready_during_rst", 64'(hv_ready_o), 64'd0);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    send(expand(32'hDEAD_BEEF), NCH, 1'b0, 1'b1, 0);
    wait_idle();

    // reset in the middle of CHECK: that stream must never report
    h = expand(32'hCAFE_F00D);
    h[100] = ~h[100];
    send(h, NCH, 1'b0, 1'b0, 0);
    rst_ni = 1'b0;
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    send(expand(SW'($urandom)), NCH, 1'b1, 1'b1, 1);
    wait_idle();

    // randomized streams
    for (int n = 0; n < 24; n++) begin
      mode = $urandom_range(0, 2);
      h = expand(SW'($urandom));
      if (mode == 1) begin
        b = $urandom_range(0, HV - 1);
        h[b] = ~h[b];
      end else if (mode == 2) begin
        for (int i = 0; i < NCH; i++) h[i*CW +: CW] = CW'($urandom);
      end
      send(h, NCH, ($urandom_range(0, 1) == 1), 1'b1, $urandom_range(0, 3));
    end
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
